// File: rtl/beamform_pkg.sv
// Shared parameters, FSM state type and focal-point delay LUT for the beamformer.
package beamform_pkg;

    localparam int unsigned DATA_W = 3;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned OUT_W  = 5;
    localparam int unsigned FP_W   = 4;
    localparam int unsigned SKIP_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SUM   = 2'd2
    } state_t;

    // Returns {delay_A, delay_B}; lower half focuses toward B, upper half toward A.
    function automatic logic [2*SKIP_W-1:0] lut_delay(input logic [FP_W-1:0] f);
        logic [SKIP_W-1:0] low;
        low = f[SKIP_W-1:0];
        if (f[FP_W-1] == 1'b0) begin
            return {SKIP_W'(0), SKIP_W'(~low)};
        end
        return {low, SKIP_W'(0)};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with registered empty/full flags.
module sync_fifo #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    output logic [DATA_W-1:0] head_c_o,
    output logic              empty_o,
    output logic              full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              empty_q;
    logic              full_q;
    logic              push_c;
    logic              pop_c;

    // A write while full is dropped even when a pop frees a slot this cycle.
    assign push_c  = wr_en_i && !full_q;
    assign pop_c   = rd_en_i && !empty_q;
    assign count_d = count_q + CW'(push_c) - CW'(pop_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            empty_q <= (count_d == CW'(0));
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign head_c_o = mem_q[rd_ptr_q];
    assign empty_o  = empty_q;
    assign full_o   = full_q;

endmodule

// File: rtl/lut_beamform_top.sv
// Two-channel delay-and-sum beamformer: per-channel FIFOs, focal-point LUT,
// leading-sample skip alignment and a registered channel sum.
module lut_beamform_top
    import beamform_pkg::*;
(
    input  logic              Clk,
    input  logic              reset,
    input  logic [FP_W-1:0]   focal_point,
    input  logic              write_en_fifo_A,
    input  logic              write_en_fifo_B,
    input  logic [DATA_W-1:0] write_data_fifo_A,
    input  logic [DATA_W-1:0] write_data_fifo_B,
    input  logic              read_en_fifo_A,
    input  logic              read_en_fifo_B,
    output logic [OUT_W-1:0]  output_data,
    output logic              fifo_A_empty,
    output logic              fifo_B_empty,
    output logic              fifo_A_full,
    output logic              fifo_B_full
);

    state_t              state_q;
    logic [SKIP_W-1:0]   skip_a_q;
    logic [SKIP_W-1:0]   skip_b_q;
    logic [OUT_W-1:0]    out_q;
    logic [DATA_W-1:0]   head_a_c;
    logic [DATA_W-1:0]   head_b_c;
    logic [2*SKIP_W-1:0] delay_c;
    logic                en_c;
    logic                pop_a_c;
    logic                pop_b_c;

    assign en_c    = read_en_fifo_A && read_en_fifo_B;
    assign delay_c = lut_delay(focal_point);

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_a (
        .clk      (Clk),
        .reset    (reset),
        .wr_en_i  (write_en_fifo_A),
        .wr_data_i(write_data_fifo_A),
        .rd_en_i  (pop_a_c),
        .head_c_o (head_a_c),
        .empty_o  (fifo_A_empty),
        .full_o   (fifo_A_full)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_b (
        .clk      (Clk),
        .reset    (reset),
        .wr_en_i  (write_en_fifo_B),
        .wr_data_i(write_data_fifo_B),
        .rd_en_i  (pop_b_c),
        .head_c_o (head_b_c),
        .empty_o  (fifo_B_empty),
        .full_o   (fifo_B_full)
    );

    // Pop requests: skipping in ALIGN stalls per channel while that FIFO is empty.
    always_comb begin
        pop_a_c = 1'b0;
        pop_b_c = 1'b0;
        if (en_c) begin
            if (state_q == ALIGN) begin
                pop_a_c = (skip_a_q != '0) && !fifo_A_empty;
                pop_b_c = (skip_b_q != '0) && !fifo_B_empty;
            end else if (state_q == SUM) begin
                pop_a_c = !fifo_A_empty && !fifo_B_empty;
                pop_b_c = !fifo_A_empty && !fifo_B_empty;
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q  <= IDLE;
            skip_a_q <= '0;
            skip_b_q <= '0;
            out_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (en_c) begin
                        skip_a_q <= delay_c[2*SKIP_W-1:SKIP_W];
                        skip_b_q <= delay_c[SKIP_W-1:0];
                        state_q  <= ALIGN;
                    end
                end
                ALIGN: begin
                    if (!en_c) begin
                        skip_a_q <= '0;
                        skip_b_q <= '0;
                        state_q  <= IDLE;
                    end else begin
                        if (pop_a_c) begin
                            skip_a_q <= skip_a_q - SKIP_W'(1);
                        end
                        if (pop_b_c) begin
                            skip_b_q <= skip_b_q - SKIP_W'(1);
                        end
                        if ((skip_a_q == '0) && (skip_b_q == '0)) begin
                            state_q <= SUM;
                        end
                    end
                end
                SUM: begin
                    if (!en_c) begin
                        state_q <= IDLE;
                    end else if (pop_a_c) begin
                        out_q <= OUT_W'(head_a_c) + OUT_W'(head_b_c);
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign output_data = out_q;

endmodule

// File: tb/tb_lut_beamform_top.sv
// Scoreboard bench for lut_beamform_top: a queue-based behavioural model pushes
// expected outputs/flags per cycle, compared after each clock edge.
module tb_lut_beamform_top;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] focal_point = 4'd0;
    logic       write_en_fifo_A = 1'b0;
    logic       write_en_fifo_B = 1'b0;
    logic [2:0] write_data_fifo_A = 3'd0;
    logic [2:0] write_data_fifo_B = 3'd0;
    logic       read_en_fifo_A = 1'b0;
    logic       read_en_fifo_B = 1'b0;
    logic [4:0] output_data;
    logic       fifo_A_empty;
    logic       fifo_B_empty;
    logic       fifo_A_full;
    logic       fifo_B_full;

    lut_beamform_top dut (
        .Clk              (Clk),
        .reset            (reset),
        .focal_point      (focal_point),
        .write_en_fifo_A  (write_en_fifo_A),
        .write_en_fifo_B  (write_en_fifo_B),
        .write_data_fifo_A(write_data_fifo_A),
        .write_data_fifo_B(write_data_fifo_B),
        .read_en_fifo_A   (read_en_fifo_A),
        .read_en_fifo_B   (read_en_fifo_B),
        .output_data      (output_data),
        .fifo_A_empty     (fifo_A_empty),
        .fifo_B_empty     (fifo_B_empty),
        .fifo_A_full      (fifo_A_full),
        .fifo_B_full      (fifo_B_full)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int out;
        int ea;
        int eb;
        int fa;
        int fb;
    } exp_t;

    exp_t sb[$];
    int   qa[$];
    int   qb[$];
    int   got[$];
    int   m_state = 0;
    int   m_skip_a = 0;
    int   m_skip_b = 0;
    int   m_out = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    int samp_a[18] = '{7,5,3,6,4,6,1,5,3,4,3,1,1,6,3,5,6,5};
    int samp_b[18] = '{5,7,1,4,6,7,3,1,6,2,0,4,5,5,5,1,7,3};
    int exp_f9[15] = '{10,10,7,8,12,8,8,4,10,5,1,5,11,8,10};
    int exp_f3[3]  = '{13,12,6};

    task automatic check_eq(input string tag, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Advance the model one cycle on the current inputs, then compare after the edge.
    task automatic step();
        exp_t e;
        bit   pa, pb, en, full_a, full_b, sum_pop;
        pa = 0; pb = 0; sum_pop = 0;
        if (reset) begin
            qa.delete(); qb.delete();
            m_state = 0; m_skip_a = 0; m_skip_b = 0; m_out = 0;
        end else begin
            en = read_en_fifo_A && read_en_fifo_B;
            case (m_state)
                0: if (en) begin
                    if (focal_point < 8) begin
                        m_skip_a = 0; m_skip_b = 7 - int'(focal_point);
                    end else begin
                        m_skip_a = int'(focal_point) - 8; m_skip_b = 0;
                    end
                    m_state = 1;
                end
                1: if (!en) begin
                    m_state = 0; m_skip_a = 0; m_skip_b = 0;
                end else begin
                    if (m_skip_a == 0 && m_skip_b == 0) m_state = 2;
                    pa = (m_skip_a != 0) && (qa.size() > 0);
                    pb = (m_skip_b != 0) && (qb.size() > 0);
                    if (pa) m_skip_a--;
                    if (pb) m_skip_b--;
                end
                default: if (!en) begin
                    m_state = 0;
                end else if (qa.size() > 0 && qb.size() > 0) begin
                    pa = 1; pb = 1; sum_pop = 1;
                    m_out = qa[0] + qb[0];
                end
            endcase
            full_a = (qa.size() == 16);
            full_b = (qb.size() == 16);
            if (pa) void'(qa.pop_front());
            if (pb) void'(qb.pop_front());
            if (write_en_fifo_A && !full_a) qa.push_back(int'(write_data_fifo_A));
            if (write_en_fifo_B && !full_b) qb.push_back(int'(write_data_fifo_B));
        end
        e.out = m_out;
        e.ea  = (qa.size() == 0) ? 1 : 0;
        e.eb  = (qb.size() == 0) ? 1 : 0;
        e.fa  = (qa.size() == 16) ? 1 : 0;
        e.fb  = (qb.size() == 16) ? 1 : 0;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        check_eq("output_data", int'(output_data), e.out);
        check_eq("fifo_A_empty", int'(fifo_A_empty), e.ea);
        check_eq("fifo_B_empty", int'(fifo_B_empty), e.eb);
        check_eq("fifo_A_full", int'(fifo_A_full), e.fa);
        check_eq("fifo_B_full", int'(fifo_B_full), e.fb);
        if (sum_pop) got.push_back(int'(output_data));
    endtask

    task automatic do_reset();
        read_en_fifo_A = 1'b0;
        read_en_fifo_B = 1'b0;
        write_en_fifo_A = 1'b0;
        write_en_fifo_B = 1'b0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++) begin
            write_en_fifo_A = 1'b1;
            write_en_fifo_B = 1'b1;
            write_data_fifo_A = 3'(samp_a[i]);
            write_data_fifo_B = 3'(samp_b[i]);
            step();
            if (i == 14) check_eq("full_A_after_15", int'(fifo_A_full), 0);
            if (i == 15) begin
                check_eq("full_A_after_16", int'(fifo_A_full), 1);
                check_eq("full_B_after_16", int'(fifo_B_full), 1);
            end
        end
        write_en_fifo_A = 1'b0;
        write_en_fifo_B = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        check_eq("rst_output", int'(output_data), 0);
        check_eq("rst_A_empty", int'(fifo_A_empty), 1);
        check_eq("rst_B_empty", int'(fifo_B_empty), 1);
        check_eq("rst_A_full", int'(fifo_A_full), 0);
        check_eq("rst_B_full", int'(fifo_B_full), 0);

        // Fill past depth, then beamform at f = 9
        fill(18);
        focal_point = 4'd9;
        got.delete();
        read_en_fifo_A = 1'b1;
        read_en_fifo_B = 1'b1;
        repeat (22) step();
        check_eq("f9_count", got.size(), 15);
        for (int i = 0; i < 15; i++) begin
            if (i < got.size()) check_eq($sformatf("f9_out%0d", i), got[i], exp_f9[i]);
        end
        check_eq("f9_hold", int'(output_data), 10);
        check_eq("f9_A_empty", int'(fifo_A_empty), 1);
        check_eq("f9_B_empty", int'(fifo_B_empty), 0);

        // Beamform at f = 3, then enable drop and re-entry with a new focal point
        do_reset();
        fill(16);
        focal_point = 4'd3;
        got.delete();
        read_en_fifo_A = 1'b1;
        read_en_fifo_B = 1'b1;
        for (int k = 0; k < 30 && got.size() < 3; k++) step();
        check_eq("f3_timeout", (got.size() >= 3) ? 1 : 0, 1);
        for (int i = 0; i < 3; i++) begin
            if (i < got.size()) check_eq($sformatf("f3_out%0d", i), got[i], exp_f3[i]);
        end
        focal_point = 4'd12;
        repeat (2) step();
        read_en_fifo_B = 1'b0;
        repeat (3) step();
        read_en_fifo_B = 1'b1;
        repeat (20) step();

        // Push+pop on a full FIFO: write dropped, count 16 -> 15
        do_reset();
        fill(16);
        focal_point = 4'd8;
        read_en_fifo_A = 1'b1;
        read_en_fifo_B = 1'b1;
        repeat (2) step();
        write_en_fifo_A = 1'b1;
        write_data_fifo_A = 3'd2;
        step();
        write_en_fifo_A = 1'b0;
        check_eq("pp_full_A_cleared", int'(fifo_A_full), 0);
        read_en_fifo_A = 1'b0;
        step();
        got.delete();
        read_en_fifo_A = 1'b1;
        repeat (25) step();
        check_eq("pp_full_drain", got.size(), 15);
        check_eq("pp_full_A_empty", int'(fifo_A_empty), 1);

        // Push+pop on a FIFO holding 5: count stays 5
        do_reset();
        fill(5);
        read_en_fifo_A = 1'b1;
        read_en_fifo_B = 1'b1;
        repeat (2) step();
        write_en_fifo_A = 1'b1;
        write_data_fifo_A = 3'd6;
        step();
        write_en_fifo_A = 1'b0;
        read_en_fifo_A = 1'b0;
        step();
        got.delete();
        read_en_fifo_A = 1'b1;
        repeat (10) step();
        check_eq("pp5_drain", got.size(), 4);
        check_eq("pp5_A_empty", int'(fifo_A_empty), 0);
        check_eq("pp5_B_empty", int'(fifo_B_empty), 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lut_beamform_top.md
# lut_beamform_top

Two-channel delay-and-sum beamformer for the ultrasound receive path. Each channel buffers 3-bit echo samples in its own synchronous FIFO. A focal-point lookup table sets how many leading samples each channel discards, which aligns the channels. The aligned samples are then summed into a 5-bit output. The block is the top level of the receive beamforming datapath: the ADC-side logic writes the FIFOs and the downstream image logic consumes `output_data`.

## Interface
- `DATA_W`, 3, sample width per channel
- `DEPTH`, 16, entries per FIFO (power of two)
- `OUT_W`, 5, output width (one spare MSB of headroom)
- `FP_W`, 4, focal-point index width
- `Clk`  in  1  system clock; all logic on the rising edge
- `reset`  in  1  synchronous, active-high
- `focal_point`  in  FP_W  focal zone index, LUT address
- `write_en_fifo_A` / `write_en_fifo_B`  in  1  push request per channel
- `write_data_fifo_A` / `write_data_fifo_B`  in  DATA_W  sample to push
- `read_en_fifo_A` / `read_en_fifo_B`  in  1  read/beamform enable per channel
- `output_data`  out  OUT_W  registered beamformed sum
- `fifo_A_empty` / `fifo_B_empty`  out  1  FIFO holds 0 entries
- `fifo_A_full` / `fifo_B_full`  out  1  FIFO holds DEPTH entries

## Operation
- **FIFOs.** Each channel has a show-ahead FIFO; the head entry is visible combinationally.
  - Push occurs when `write_en` is high and the FIFO is not full.
  - A write while full is dropped, even if a pop happens in the same cycle.
  - A pop on an empty FIFO is ignored.
  - Push and pop in the same cycle are both allowed; the count is unchanged.
  - Pointers wrap modulo DEPTH.
- **LUT** (combinational, indexed by `focal_point`):
  - f = 0..7: delay_A = 0, delay_B = 7 − f.
  - f = 8..15: delay_A = f − 8, delay_B = 0.
- **FSM states:** IDLE, ALIGN, SUM.
  - **IDLE:** no pops. If `read_en_fifo_A` and `read_en_fifo_B` are both high, latch skip_A = delay_A and skip_B = delay_B, then go to ALIGN.
  - **ALIGN:** each cycle, pop A if skip_A ≠ 0 and A is not empty, then decrement skip_A; do the same for B. When both skip counters are 0 at a clock edge, go to SUM. Skipping on one channel stalls, without error, while that FIFO is empty.
  - **SUM:** if both FIFOs are non-empty, pop both and set `output_data` <= zero-extended head_A + head_B. Otherwise, no pop and `output_data` holds its value.
  - From ALIGN or SUM, if either `read_en` is low, go to IDLE; any remaining skip count is discarded.
- **Arithmetic:** unsigned. The maximum sum is 14, so MSB[4] is always 0 in this 2-channel configuration.
- **Focal point changes:** a change of `focal_point` outside IDLE has no effect until the next entry into ALIGN.

## Timing
- **Reset values:**
  - `output_data` = 0
  - both FIFOs empty: `*_empty` = 1, `*_full` = 0
  - pointers, counts and skip counters = 0
  - state = IDLE
- **Reset mid-operation:** reset wins over every other input in that cycle.
- **Write flags:** a push at edge N updates `empty`/`full` right after edge N; write-to-flag latency is 1 cycle.
- **Read latency:** the first IDLE edge with both enables high moves to ALIGN. Each ALIGN edge consumes one skip. The first SUM pop happens one edge after the skip counters reach 0. `output_data` is valid right after the popping edge; latency is 1 cycle.
- **Zero skip:** with both skips 0, ALIGN lasts exactly one cycle.

## Structure
- **Shared package `beamform_pkg`:** DATA_W, DEPTH, OUT_W, FP_W, the state enum (IDLE/ALIGN/SUM), and the `lut_delay(f)` function returning {delay_A, delay_B}.
- **Sub-module `sync_fifo`:** parameterized by DATA_W and DEPTH, show-ahead, with full/empty flags. It is instantiated twice.
- **Top level:** contains the LUT, the FSM, the skip counters and the output register.

## Test plan
1. **Reset:** assert reset for 2 cycles → `output_data` = 0, `fifo_A_empty` = `fifo_B_empty` = 1, both full flags = 0.
2. **Fill past depth:**
   - Stimulus: push 18 samples per channel on back-to-back cycles.
     - A: 7,5,3,6,4,6,1,5,3,4,3,1,1,6,3,5,6,5
     - B: 5,7,1,4,6,7,3,1,6,2,0,4,5,5,5,1,7,3
   - Required response: full flags assert after the 16th push; pushes 17 and 18 are dropped.
3. **Beamform at f = 9:** continuing from scenario 2, raise both read enables.
   - Delays are A = 1, B = 0.
   - Required outputs: 10,10,7,8,12,8,8,4,10,5,1,5,11,8,10.
   - Then A goes empty and the output holds at 10; `fifo_A_empty` = 1, `fifo_B_empty` = 0.
4. **Beamform at f = 3** (same fill): delays are A = 0, B = 4. First outputs are 7+6 = 13, 5+7 = 12, 3+3 = 6.
5. **Enable drop:** deassert `read_en_fifo_B` mid-SUM → no further pops and the output holds. Re-asserting the enable re-enters ALIGN with a fresh LUT lookup.
6. **Simultaneous push and pop:** push and pop on a FIFO holding 16 entries → the write is dropped and the count becomes 15. Push and pop on a FIFO holding 5 entries → the count stays 5.
